// File: rtl/pencoder_q.sv
// Registered priority encoder with sticky pending requests. Grants come out
// one at a time through a valid/ready register, by fixed priority or round-robin.
module pencoder_q #(
  parameter  int N = 8,
  localparam int W = (N > 2) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         clr,
  input  logic         rr_en,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pend,
  output logic         any,
  output logic         coal
);

  logic [N-1:0] r_pend;
  logic [W-1:0] r_ptr;
  logic [W-1:0] r_idx;
  logic         r_valid;
  logic         r_coal;

  logic [N-1:0] w_cand;
  logic [N-1:0] w_oneHot;
  logic [W-1:0] w_fixIdx;
  logic [W-1:0] w_rrIdx;
  logic [W-1:0] w_probe;
  logic [W-1:0] w_winner;
  logic         w_load;

  assign w_cand = r_pend | req;

  always_comb begin
    w_fixIdx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_cand[i]) w_fixIdx = W'(i);
    end
  end

  // Probe ptr-1, ptr-2, ... wrapping to N-1, with ptr itself last; the
  // loop runs from the farthest probe inwards so the nearest hit wins.
  always_comb begin
    w_rrIdx = '0;
    w_probe = '0;
    for (int k = N; k >= 1; k--) begin
      if (int'(r_ptr) >= k) w_probe = W'(int'(r_ptr) - k);
      else                  w_probe = W'(int'(r_ptr) - k + N);
      if (w_cand[w_probe]) w_rrIdx = w_probe;
    end
  end

  assign w_winner = rr_en ? w_rrIdx : w_fixIdx;
  assign w_oneHot = N'(1) << w_winner;
  assign w_load   = !clr && (!r_valid || out_ready) && (|w_cand);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= '0;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_coal  <= 1'b0;
    end else begin
      if (clr) begin
        r_pend <= '0;
        r_coal <= 1'b0;
      end else begin
        r_pend <= w_load ? (w_cand & ~w_oneHot) : w_cand;
        if (|(req & r_pend)) r_coal <= 1'b1;
      end

      // The output register ignores clr so an in-flight transfer completes.
      if (w_load) begin
        r_ptr   <= w_winner;
        r_idx   <= w_winner;
        r_valid <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_idx   = r_idx;
  assign pend      = r_pend;
  assign any       = |r_pend;
  assign coal      = r_coal;

endmodule

// File: tb/tb_pencoder_q.sv
// Scoreboard bench for pencoder_q: directed vectors push expected grants,
// negedge monitors pop and compare on every transfer.
module tb_pencoder_q;

  logic       clk;
  logic       rst_n;

  logic [7:0] req;
  logic       clr;
  logic       rrEn;
  logic       outReady;
  logic       outValid;
  logic [2:0] outIdx;
  logic [7:0] pend;
  logic       anyOut;
  logic       coal;

  logic [4:0] req5;
  logic       clr5;
  logic       rrEn5;
  logic       outReady5;
  logic       outValid5;
  logic [2:0] outIdx5;
  logic [4:0] pend5;
  logic       anyOut5;
  logic       coal5;

  int checks;
  int errors;
  int expQ[$];
  int expQ5[$];

  pencoder_q #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .clr(clr), .rr_en(rrEn),
    .out_ready(outReady), .out_valid(outValid), .out_idx(outIdx),
    .pend(pend), .any(anyOut), .coal(coal)
  );

  pencoder_q #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .clr(clr5), .rr_en(rrEn5),
    .out_ready(outReady5), .out_valid(outValid5), .out_idx(outIdx5),
    .pend(pend5), .any(anyOut5), .coal(coal5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic c, input logic rr, input logic rdy);
    req      = r;
    clr      = c;
    rrEn     = rr;
    outReady = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transfers happen on the next rising edge whenever valid && ready here.
  always @(negedge clk) begin
    if (rst_n && outValid && outReady) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL grant8: unexpected index %0d with empty scoreboard", outIdx);
      end else begin
        checkOutput("grant8", 64'(outIdx), 64'(expQ.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && outValid5 && outReady5) begin
      if (expQ5.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL grant5: unexpected index %0d with empty scoreboard", outIdx5);
      end else begin
        checkOutput("grant5", 64'(outIdx5), 64'(expQ5.pop_front()));
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    req5      = '0;
    clr5      = 1'b0;
    rrEn5     = 1'b0;
    outReady5 = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] asynchronous reset mid-transfer");
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("preResetPend", 64'(pend), 64'h FF);
    checkOutput("preResetValid", 64'(outValid), 64'd1);
    checkOutput("preResetCoal", 64'(coal), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstValid", 64'(outValid), 64'd0);
    checkOutput("rstIdx", 64'(outIdx), 64'd0);
    checkOutput("rstPend", 64'(pend), 64'd0);
    checkOutput("rstAny", 64'(anyOut), 64'd0);
    checkOutput("rstCoal", 64'(coal), 64'd0);
    #1 rst_n = 1'b1;
    tick();

    $display("[TB] fixed priority");
    applyStimulus(8'h0A, 1'b0, 1'b0, 1'b1);
    expQ.push_back(3);
    expQ.push_back(1);
    tick();
    checkOutput("fixLatencyValid", 64'(outValid), 64'd1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("fixDoneValid", 64'(outValid), 64'd0);
    checkOutput("fixDonePend", 64'(pend), 64'd0);
    checkOutput("fixDoneAny", 64'(anyOut), 64'd0);

    $display("[TB] backpressure");
    applyStimulus(8'h81, 1'b0, 1'b0, 1'b0);
    expQ.push_back(7);
    expQ.push_back(0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("bpIdx", 64'(outIdx), 64'd7);
    checkOutput("bpValid", 64'(outValid), 64'd1);
    checkOutput("bpPend", 64'(pend), 64'h01);
    checkOutput("bpAny", 64'(anyOut), 64'd1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("bpSecondIdx", 64'(outIdx), 64'd0);
    tick();
    checkOutput("bpDoneValid", 64'(outValid), 64'd0);

    $display("[TB] round-robin then fixed with all requests held");
    applyStimulus(8'hFF, 1'b0, 1'b1, 1'b1);
    for (int i = 7; i >= 0; i--) expQ.push_back(i);
    expQ.push_back(7);
    repeat (9) tick();
    checkOutput("rrCoal", 64'(coal), 64'd1);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1);
    repeat (3) expQ.push_back(7);
    repeat (3) tick();
    checkOutput("fixCoal", 64'(coal), 64'd1);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("clrDrainValid", 64'(outValid), 64'd0);
    checkOutput("clrDrainPend", 64'(pend), 64'd0);
    checkOutput("clrDrainCoal", 64'(coal), 64'd0);

    $display("[TB] coalescing and clear under backpressure");
    applyStimulus(8'h80, 1'b0, 1'b0, 1'b0);
    expQ.push_back(7);
    tick();
    applyStimulus(8'h04, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("coalFirstReq", 64'(coal), 64'd0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("coalPend", 64'(pend), 64'h04);
    checkOutput("coalFlag", 64'(coal), 64'd1);
    applyStimulus(8'h10, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("clrPend", 64'(pend), 64'd0);
    checkOutput("clrCoal", 64'(coal), 64'd0);
    checkOutput("clrKeepValid", 64'(outValid), 64'd1);
    checkOutput("clrKeepIdx", 64'(outIdx), 64'd7);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("clrDoneValid", 64'(outValid), 64'd0);

    $display("[TB] N=5 round-robin wrap");
    req5      = 5'h11;
    rrEn5     = 1'b1;
    outReady5 = 1'b1;
    expQ5.push_back(4);
    expQ5.push_back(0);
    expQ5.push_back(4);
    expQ5.push_back(0);
    repeat (4) tick();
    req5 = 5'h00;
    clr5 = 1'b1;
    tick();
    clr5 = 1'b0;
    checkOutput("n5DoneValid", 64'(outValid5), 64'd0);
    checkOutput("n5DonePend", 64'(pend5), 64'd0);

    tick();
    checkOutput("scoreboard8Empty", 64'(expQ.size()), 64'd0);
    checkOutput("scoreboard5Empty", 64'(expQ5.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pencoder_q.md
# pencoder_q

Parametrised, registered successor to the 4-bit combinational priority encoder. It accepts N request lines and holds each request in a sticky pending register until it is granted. Each cycle it selects one winner, by fixed priority or by round-robin, and delivers the winner's index through a valid/ready output register. It sits between interrupt/event sources and a single consumer that services one index at a time.

## Interface
Parameters:
- N, 8: number of request lines; legal range 2..64, need not be a power of two.
- W, derived max(1, clog2(N)): index width. Localparam, not overridable.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  request events; any cycle with req[i]=1 raises request i.
- clr  in  1  synchronous clear of the pending state and the coal flag.
- rr_en  in  1  0 = fixed priority (highest index wins); 1 = round-robin.
- out_ready  in  1  consumer accepts out_idx this cycle.
- out_valid  out  1  out_idx holds a granted request.
- out_idx  out  W  granted index.
- pend  out  N  pending register P (granted bits excluded).
- any  out  1  |P, combinational from the register.
- coal  out  1  sticky flag: a request arrived on a bit already pending.

## Operation
- Candidate vector: C = P | req.
- Load condition: load = !clr && (!out_valid || out_ready) && (C != 0).
- Fixed mode (rr_en=0): the winner is the highest set index of C.
- Round-robin mode (rr_en=1):
  - Search C downward, starting at ptr-1 and wrapping from 0 to N-1.
  - ptr itself is searched last.
  - The winner is the first set bit found.
- Pointer ptr (W bits):
  - Reset value 0, so the first round-robin search starts at N-1.
  - On every load, ptr <= winner, in either mode.
- Pending register update:
  - On load: P <= C & ~onehot(winner). A req on the winning bit in the same cycle is consumed.
  - No load and no clr: P <= C.
  - On clr: P <= 0. req in that cycle is discarded, and no load occurs.
- Output register:
  - On load: out_idx <= winner and out_valid <= 1.
  - On out_valid && out_ready && !load: out_valid <= 0, and out_idx holds its value.
  - clr does not affect the output register. A transfer (out_valid && out_ready) during clr still completes and out_valid falls.
- Coalescing:
  - Repeated requests on a bit that is still pending merge into one grant.
  - coal <= 1 whenever any req[i] && P[i]; this applies to the register P, not the bypass.
  - coal is cleared only by clr or reset.
- mode switching: rr_en may change on any cycle and takes effect for that cycle's selection. ptr is unaffected.

## Timing
- Reset (asynchronous, immediate on rst_n low, including mid-transfer): P=0, out_valid=0, out_idx=0, ptr=0, coal=0, any=0.
- Latency:
  - req in cycle t with the output register free: out_valid=1 with the index after edge t+1.
  - Zero-cycle bypass through C; there is no extra pipeline stage.
- Throughput: one grant per cycle while out_ready=1 and C is non-zero.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_idx and out_valid hold.
  - New requests accumulate in P.
- Transfer: occurs on any edge with out_valid && out_ready. The next grant may load on the same edge (back-to-back).
- Simultaneous events:
  - clr beats load and req.
  - req on a bit being granted is absorbed by that grant.

## Test plan
- Reset: N=8, drive P to 0xFF with out_ready=0 and out_valid=1, then pulse rst_n low between edges -> out_valid, out_idx, pend, any and coal all read 0 immediately, before the next edge.
- Fixed priority: rr_en=0, out_ready=1, one-cycle req=0x0A -> out_idx 3, then 1, on consecutive cycles with out_valid=1; then out_valid=0, pend=0x00, any=0.
- Backpressure: out_ready=0, one-cycle req=0x81 -> out_idx=7 held, pend=0x01. Raise out_ready -> the next cycle shows out_idx=0, then out_valid=0.
- Round-robin versus fixed: req=0xFF held, out_ready=1.
  - rr_en=1 -> grant sequence 7,6,5,4,3,2,1,0,7.
  - rr_en=0 -> 7 on every cycle.
  - coal=1 in both modes.
- Coalesce and clr: out_ready=0 with index 7 held; req bit2 on two consecutive cycles -> pend=0x04, coal=1. Then clr together with req=0x10 -> pend=0x00, coal=0, out_valid still 1 with out_idx=7.
- Non-power-of-two: N=5, rr_en=1, ptr=0 after reset, req=0x11 held -> grants 4,0,4,0 (wrap from 0 to 4, not to 7).
